// File: rtl/memory_subsystem_if.sv
// rtl/memory_subsystem_if.sv - request/response bundle between sequencer and memory
interface memory_subsystem_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        read;
  logic        write;
  logic [31:0] Mdatain;
  logic        MFC;
  logic        busy;
  logic        err;

  modport master (
    output address, data_in, read, write,
    input  Mdatain, MFC, busy, err
  );

  modport slave (
    input  address, data_in, read, write,
    output Mdatain, MFC, busy, err
  );
endinterface

// File: rtl/memory_subsystem.sv
// rtl/memory_subsystem.sv - wait-stated word RAM answering MAR/MDR requests with an MFC pulse
module memory_subsystem #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  memory_subsystem_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic        read_q, write_q;
  logic        rd_req, wr_req;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] addr_lat, data_lat;
  logic        op_wr;
  logic        latch_req;
  logic        do_access;
  logic        in_range;
  logic        err_q, err_nx;
  logic [31:0] mdat_q;
  logic [31:0] mem [DEPTH];

  assign rd_req   = bus.read & ~read_q;
  assign wr_req   = bus.write & ~write_q;
  assign in_range = (addr_lat[31:ADDR_W] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    latch_req = 1'b0;
    do_access = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req ^ wr_req) begin
          latch_req = 1'b1;
          cnt_nx    = WAIT_INIT;
          state_nx  = BUSY;
        end else if (rd_req && wr_req) begin
          err_nx = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          do_access = 1'b1;
          state_nx  = DONE;
          if (!in_range) err_nx = 1'b1;
        end
        // New request edges while a transaction is in flight are dropped.
        if (rd_req || wr_req) err_nx = 1'b1;
      end
      DONE: begin
        state_nx = IDLE;
        if (rd_req || wr_req) err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      cnt      <= 4'd0;
      addr_lat <= 32'd0;
      data_lat <= 32'd0;
      op_wr    <= 1'b0;
      err_q    <= 1'b0;
      mdat_q   <= 32'd0;
    end else begin
      read_q  <= bus.read;
      write_q <= bus.write;
      cnt     <= cnt_nx;
      err_q   <= err_nx;
      if (latch_req) begin
        addr_lat <= bus.address;
        data_lat <= bus.data_in;
        op_wr    <= wr_req;
      end
      if (do_access && !op_wr && in_range)
        mdat_q <= mem[addr_lat[ADDR_W-1:0]];
    end
  end

  // Array has no reset; do_access is gated off by the state reset.
  always_ff @(posedge clk) begin
    if (do_access && op_wr && in_range)
      mem[addr_lat[ADDR_W-1:0]] <= data_lat;
  end

  assign bus.Mdatain = mdat_q;
  assign bus.MFC     = (state == DONE);
  assign bus.busy    = (state != IDLE);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_memory_subsystem.sv
// tb/tb_memory_subsystem.sv - scoreboard bench for memory_subsystem at W=2, W=0 and W=3
module tb_memory_subsystem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  int          busy_run = 0;

  typedef struct {
    int          acc;
    int          lat;
    logic [31:0] data;
    bit          chk;
    bit          err;
  } exp_t;

  exp_t sb[$];

  memory_subsystem_if if0 ();
  memory_subsystem_if if1 ();
  memory_subsystem_if if2 ();

  assign if0.address = address;
  assign if0.data_in = data_in;
  assign if0.read    = read && (sel == 0);
  assign if0.write   = write && (sel == 0);
  assign if1.address = address;
  assign if1.data_in = data_in;
  assign if1.read    = read && (sel == 1);
  assign if1.write   = write && (sel == 1);
  assign if2.address = address;
  assign if2.data_in = data_in;
  assign if2.read    = read && (sel == 2);
  assign if2.write   = write && (sel == 2);

  memory_subsystem #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(2)) dut_w2 (.clk(clk), .rst_n(rst_n), .bus(if0));
  memory_subsystem #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .rst_n(rst_n), .bus(if1));
  memory_subsystem #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(3)) dut_w3 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [2:0]  mfc, err, busy;
  logic [31:0] mdat [3];

  assign mfc  = {if2.MFC, if1.MFC, if0.MFC};
  assign err  = {if2.err, if1.err, if0.err};
  assign busy = {if2.busy, if1.busy, if0.busy};
  assign mdat[0] = if0.Mdatain;
  assign mdat[1] = if1.Mdatain;
  assign mdat[2] = if2.Mdatain;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic int wof(input int s);
    case (s)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per MFC pulse of the selected unit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (i != sel && (mfc[i] || err[i]))
          check("unselected_unit_quiet", {30'd0, mfc[i], err[i]}, 32'd0);
      if (mfc[sel]) begin
        if (sb.size() == 0) begin
          check("unexpected_mfc", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("mfc_latency", 32'(cyc - e.acc), 32'(e.lat));
          if (e.chk) check("read_data", mdat[sel], e.data);
          check("err_with_mfc", {31'd0, err[sel]}, {31'd0, e.err});
        end
      end else if (err[sel]) begin
        err_seen = err_seen + 1;
      end
      if (busy[sel]) begin
        busy_run = busy_run + 1;
      end else begin
        if (busy_run != 0) check("busy_width", 32'(busy_run), 32'(wof(sel) + 2));
        busy_run = 0;
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input bit chk_d, input bit e_err);
    exp_t e;
    e.acc  = cyc + 1;
    e.lat  = wof(sel) + 1;
    e.data = d;
    e.chk  = chk_d;
    e.err  = e_err;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("completion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic req(input bit rd, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input bit chk_d, input bit e_err);
    address = a;
    data_in = d;
    if (rd) read = 1'b1;
    else    write = 1'b1;
    push_exp(exp_d, chk_d, e_err);
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      check("reset_mdatain", mdat[i], 32'd0);
      check("reset_flags", {29'd0, mfc[i], busy[i], err[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read, W=2
    sel = 0;
    req(1'b0, 32'd5, 32'h0000_0022, 32'd0, 1'b0, 1'b0);
    req(1'b1, 32'd5, 32'd0, 32'h0000_0022, 1'b1, 1'b0);
    check("err_count_wr_rd", 32'(err_seen), 32'(err_exp));

    // Latency at W=0 and W=3
    sel = 1;
    req(1'b0, 32'd0, 32'h0000_00A0, 32'd0, 1'b0, 1'b0);
    req(1'b1, 32'd0, 32'd0, 32'h0000_00A0, 1'b1, 1'b0);
    sel = 2;
    req(1'b0, 32'd0, 32'h0000_00B3, 32'd0, 1'b0, 1'b0);
    req(1'b1, 32'd0, 32'd0, 32'h0000_00B3, 1'b1, 1'b0);

    // Held read level gives one MFC; a drop and re-raise gives another
    sel = 0;
    req(1'b0, 32'd7, 32'h0000_0077, 32'd0, 1'b0, 1'b0);
    address = 32'd7;
    read = 1'b1;
    push_exp(32'h0000_0077, 1'b1, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    read = 1'b0;
    @(posedge clk);
    #1;
    read = 1'b1;
    push_exp(32'h0000_0077, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    wait_idle();
    read = 1'b0;
    wait_idle();
    check("err_count_held", 32'(err_seen), 32'(err_exp));

    // Read and write on the same edge
    address = 32'd5;
    data_in = 32'h0000_0055;
    read = 1'b1;
    write = 1'b1;
    err_exp++;
    @(posedge clk);
    #1;
    read = 1'b0;
    write = 1'b0;
    wait_idle();
    check("err_count_both", 32'(err_seen), 32'(err_exp));
    req(1'b1, 32'd5, 32'd0, 32'h0000_0022, 1'b1, 1'b0);

    // Out-of-range read keeps previous Mdatain
    req(1'b1, 32'h0000_0200, 32'd0, 32'h0000_0022, 1'b1, 1'b1);
    check("err_count_range", 32'(err_seen), 32'(err_exp));

    // Write edge during BUSY of a read is dropped
    address = 32'd5;
    read = 1'b1;
    push_exp(32'h0000_0022, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    read = 1'b0;
    data_in = 32'h0000_0099;
    write = 1'b1;
    err_exp++;
    @(posedge clk);
    #1;
    write = 1'b0;
    wait_idle();
    check("err_count_overrun", 32'(err_seen), 32'(err_exp));
    req(1'b1, 32'd5, 32'd0, 32'h0000_0022, 1'b1, 1'b0);

    // Reset one cycle after accepting a write, W=3
    sel = 2;
    req(1'b0, 32'd3, 32'h1111_1111, 32'd0, 1'b0, 1'b0);
    address = 32'd3;
    data_in = 32'hDEAD_BEEF;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midop_reset_mdatain", mdat[2], 32'd0);
    check("midop_reset_flags", {29'd0, mfc[2], busy[2], err[2]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(1'b1, 32'd3, 32'd0, 32'h1111_1111, 1'b1, 1'b0);
    check("err_count_final", 32'(err_seen), 32'(err_exp));
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_subsystem.md
# memory_subsystem

Word-addressed RAM that answers the datapath's memory requests: it samples the address from MAR and the write data from MDR, and returns read data on `Mdatain`. It completes every request with a one-cycle `MFC` (memory function complete) pulse after a configurable number of wait states. It sits between the Datapath's MAR/MDR outputs and its `Mdatain`/`read` inputs, so the control sequencer can stall on `MFC` instead of relying on fixed delays.

## Interface
- `DEPTH`, 512: number of 32-bit words.
- `ADDR_W`, 9: index width; DEPTH = 2^ADDR_W.
- `WAIT_CYCLES`, 2: wait states before the access; legal range 0–15.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `address` input 32: byte-free word address from MAR.
- `data_in` input 32: write data from MDR.
- `read` input 1: read request, level from the sequencer.
- `write` input 1: write request, level from the sequencer.
- `Mdatain` output 32: read data to the MDR input mux; holds its value between reads.
- `MFC` output 1: one-cycle completion pulse.
- `busy` output 1: high in BUSY and DONE.
- `err` output 1: one-cycle error pulse.

## Operation
- State machine has three states: IDLE, BUSY and DONE.
- Edge detect: registers `read_q` and `write_q` capture the previous `read` and `write` values every cycle.
  - `rd_req = read & ~read_q`; `wr_req = write & ~write_q`.
  - A level held high across cycles raises exactly one request.
- IDLE:
  - `rd_req` xor `wr_req`: latch `address`, `data_in` and the op; load `cnt = WAIT_CYCLES`; go to BUSY.
  - `rd_req` and `wr_req` on the same edge: no access, state stays IDLE, `err` = 1 for one cycle, no `MFC`.
- BUSY:
  - `cnt != 0`: decrement `cnt`.
  - `cnt == 0`: perform the access at this edge and go to DONE.
    - Write: `mem[addr_lat[ADDR_W-1:0]] <= data_lat`.
    - Read: `Mdatain <= mem[addr_lat[ADDR_W-1:0]]`.
- DONE: `MFC` = 1 for this one cycle; the next edge returns to IDLE unconditionally.
- Out of range (`addr_lat[31:ADDR_W] != 0`):
  - At the access edge, memory and `Mdatain` are left unchanged.
  - DONE is still entered, so `MFC` = 1 and `err` = 1 in the same cycle and the sequencer never hangs.
- Overrun: a request edge (`rd_req` or `wr_req`) while in BUSY or DONE is dropped and pulses `err` for one cycle. The latched transaction is unaffected.
- Memory array is never reset.
- Read-after-write to the same address returns the new data, because the transactions are serialized.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - State goes to IDLE.
  - `Mdatain` = 0, `MFC` = 0, `busy` = 0, `err` = 0.
  - `read_q` = 0, `write_q` = 0, `cnt` = 0.
- Reset during BUSY abandons the transaction: no write occurs and no `MFC` is produced.
- Request accepted at edge k; with W = WAIT_CYCLES:
  - Access occurs at edge k+W+1.
  - `MFC` is high from edge k+W+1 to edge k+W+2.
  - IDLE is re-entered at edge k+W+2.
- `Mdatain` becomes valid on the same edge `MFC` rises and is stable until the next successful read completes.
- Back-to-back requests: the earliest next acceptance is edge k+W+3. `read` must fall and rise again, because `read_q` must see a 0 first.
- `busy` rises at edge k and falls at edge k+W+2.
- `err` is registered, high for exactly one cycle per error event.
- If an overrun and an out-of-range completion coincide, `err` is still one cycle; this is not double counted.

## Test plan
- Write then read, W = 2:
  - Stimulus: write 0x00000022 to address 5, then read address 5.
  - Required: `MFC` rises 3 cycles after each accept; `Mdatain` = 0x00000022; `err` = 0 throughout.
- Latency and `busy`, W = 0 and W = 3:
  - Stimulus: read address 0.
  - Required: `MFC` 1 and 4 cycles after accept respectively; `busy` high for exactly W+2 cycles.
- Held level:
  - Stimulus: hold `read` high for 10 cycles at address 7.
  - Required: exactly one `MFC` pulse and no `err`.
  - Stimulus: drop `read` one cycle and reassert it.
  - Required: a second `MFC` pulse.
- Illegal requests:
  - Stimulus: raise `read` and `write` on the same edge.
  - Required: `err` pulse; no `MFC`; memory unchanged, confirmed by readback.
  - Stimulus: read `address` = 0x00000200.
  - Required: `MFC` and `err` high together; `Mdatain` keeps its previous value.
- Overrun:
  - Stimulus: `wr_req` edge arrives during BUSY of a read.
  - Required: one `err` pulse; the read completes with correct data; the write never lands.
- Reset mid-op:
  - Stimulus: write 0xDEADBEEF to address 3; assert `rst_n` = 0 one cycle after accept, with W = 3.
  - Required: outputs are 0 immediately; no `MFC`; a later read of address 3 returns the prior contents.
